char_disp_pixel_engine: RTL
===========================

// Module: char_disp_pixel_engine
// PURPOSE
// Parametrised text-mode pixel engine: successor to the fixed 8x8, 3-bit-colour character display path.
// Consumes display_on/h_sync/v_sync/frame_start from the external timing generator; fetches cell words from a frame-buffer read port and glyph rows from a char-ROM read port.
// Emits per-cell foreground/background RGB, hardware vertical scroll and a blinking underline cursor, all on one pixel clock.
// PARAMETERS
// COLOR_W         4    bits per colour channel; cell word = {fg_r,fg_g,fg_b,bg_r,bg_g,bg_b,code}
// CODE_W          8    character code width (ROM holds 2**CODE_W glyphs)
// GLYPH_H         16   glyph rows per text row (8 or 16); glyph width fixed at 8 px
// COLS            100  text columns per line
// ROWS            37   text rows per frame
// ADDR_W          12   frame-buffer address width, 2**ADDR_W >= COLS*ROWS
// BLINK_FRAMES    30   frames per cursor blink half-period
// SYNC_ACTIVE_LOW 1    1: hsync/vsync outputs inverted relative to inputs
// PORTS
// pixclk        in   1              pixel clock; all logic on rising edge
// reset_pix_n   in   1              synchronous reset, active low
// display_on    in   1              active-pixel window, contiguous per line
// h_sync_in     in   1              horizontal sync, active high
// v_sync_in     in   1              vertical sync, active high
// frame_start   in   1              1-cycle pulse in vblank before first active line
// scroll_row    in   log2(ROWS)     text row shown at screen top; sampled on frame_start
// cursor_en     in   1              cursor enable; sampled on frame_start
// cursor_col    in   log2(COLS)     cursor screen column; sampled on frame_start
// cursor_row    in   log2(ROWS)     cursor screen row (post-scroll); sampled on frame_start
// fb_addr       out  ADDR_W         frame-buffer read address
// fb_rdata      in   6*COLOR_W+CODE_W  cell word, valid 1 cycle after fb_addr
// rom_code      out  CODE_W         glyph code to char ROM
// rom_row       out  log2(GLYPH_H)  glyph row to char ROM
// rom_data      in   8              glyph row, valid 1 cycle after rom_code/rom_row; bit0 = leftmost pixel
// vga_red/green/blue  out  COLOR_W  pixel colour
// vga_hsync     out  1              delayed h_sync_in (polarity per SYNC_ACTIVE_LOW)
// vga_vsync     out  1              delayed v_sync_in
// de_out        out  1              delayed display_on
// BEHAVIOUR
// - Reset: counters, pipeline and frame_valid cleared; RGB=0, de_out=0, syncs at inactive level, fb_addr=0.
// - Reset mid-frame: output blank (RGB=0) until the next frame_start sets frame_valid.
// - Counters: px (0..7), col, gy (0..GLYPH_H-1), row. frame_start zeroes all and loads row_base=scroll_row*COLS; frame_start wins over any other event in the same cycle.
// - px/col advance each display_on cycle; px wraps 7->0 with col+1.
// - display_on falling edge: px,col:=0; gy+1; gy wrap -> row+1, row_base+=COLS, wrapping to 0 at ROWS*COLS (scroll wrap).
// - fb_addr = row_base+col (combinational from registers, T0). T1: rom_code=fb_rdata code, rom_row=gy (delayed), colours latched. T2: rom_data valid, bit px(delayed 2) selects fg/bg. T3: registered RGB.
// - Pixel latency 3 cycles: de_out, vga_hsync, vga_vsync are 3-stage delays of their inputs, phase-aligned with RGB.
// - RGB = 0 when delayed de is low, frame_valid is 0, col>=COLS, or row>=ROWS (fb_addr held at last value in those regions).
// - scroll_row>=ROWS is treated as 0. Cursor suppressed if cursor_row>=ROWS or cursor_col>=COLS.
// - Cursor: frame counter toggles blink phase every BLINK_FRAMES frame_starts. When cursor_en, phase=1, and the cell matches: glyph rows GLYPH_H-2, GLYPH_H-1 are forced to fg colour.
// - Widths: row_base and fb_addr are ADDR_W bits; no overflow when COLS*ROWS <= 2**ADDR_W.
// TESTING
// - Reset low 4 cycles mid-line -> RGB=0, de_out=0, hsync=vsync=1 (SYNC_ACTIVE_LOW=1); stays blank until frame_start.
// - Cell 0 = {fg=F,F,F, bg=0,0,1, code=0x41}, rom_data=8'h01 -> de_out rises 3 cycles after display_on; first pixel RGB=FFF, next 7 pixels RGB=001.
// - scroll_row=36, COLS=100 -> first fb_addr=3600; after 16 lines fb_addr=0 (wrap).
// - cursor_en=1 at (col 5,row 2), BLINK_FRAMES=2 -> glyph rows 14,15 of that cell all fg in frames 2-3, glyph as-is in frames 0-1 and 4-5.
// - display_on held 808 px -> pixels 800..807 have RGB=0; fb_addr unchanged.
// - frame_start coincident with display_on falling edge -> counters zero, row_base=scroll_row*COLS, no gy increment.

Source files
------------

// File: rtl/char_disp_pixel_engine_if.sv
// Text-mode pixel engine signal bundle: timing-generator inputs, cursor/scroll
// configuration, frame-buffer and char-ROM read ports, and the video outputs.
interface char_disp_pixel_engine_if #(
  parameter int COLOR_W = 4,
  parameter int CODE_W  = 8,
  parameter int GLYPH_H = 16,
  parameter int COLS    = 100,
  parameter int ROWS    = 37,
  parameter int ADDR_W  = 12
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int GW = $clog2(GLYPH_H);
  localparam int FW = 6 * COLOR_W + CODE_W;

  logic               display_on;
  logic               h_sync_in;
  logic               v_sync_in;
  logic               frame_start;
  logic [RW-1:0]      scroll_row;
  logic               cursor_en;
  logic [CW-1:0]      cursor_col;
  logic [RW-1:0]      cursor_row;
  logic [ADDR_W-1:0]  fb_addr;
  logic [FW-1:0]      fb_rdata;
  logic [CODE_W-1:0]  rom_code;
  logic [GW-1:0]      rom_row;
  logic [7:0]         rom_data;
  logic [COLOR_W-1:0] vga_red;
  logic [COLOR_W-1:0] vga_green;
  logic [COLOR_W-1:0] vga_blue;
  logic               vga_hsync;
  logic               vga_vsync;
  logic               de_out;

  // Engine side
  modport slave (
    input  display_on, h_sync_in, v_sync_in, frame_start,
    input  scroll_row, cursor_en, cursor_col, cursor_row,
    input  fb_rdata, rom_data,
    output fb_addr, rom_code, rom_row,
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, de_out
  );

  // Timing generator / memories / display side
  modport master (
    output display_on, h_sync_in, v_sync_in, frame_start,
    output scroll_row, cursor_en, cursor_col, cursor_row,
    output fb_rdata, rom_data,
    input  fb_addr, rom_code, rom_row,
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, de_out
  );
endinterface

// File: rtl/char_disp_pixel_engine.sv
// Text-mode pixel engine: walks the cell grid, fetches cell words and glyph
// rows, and emits fg/bg colour with vertical scroll and a blinking underline
// cursor. Pipeline: T0 fb_addr, T1 rom fetch, T2 pixel select, T3 RGB out.
module char_disp_pixel_engine #(
  parameter int COLOR_W         = 4,
  parameter int CODE_W          = 8,
  parameter int GLYPH_H         = 16,
  parameter int COLS            = 100,
  parameter int ROWS            = 37,
  parameter int ADDR_W          = 12,
  parameter int BLINK_FRAMES    = 30,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic pixclk,
  input  logic reset_pix_n,
  char_disp_pixel_engine_if.slave bus
);
  localparam int GW  = $clog2(GLYPH_H);
  localparam int CCW = $clog2(COLS + 1);   // col counter may reach COLS
  localparam int RCW = $clog2(ROWS + 1);   // row counter may reach ROWS
  localparam int BW  = $clog2(BLINK_FRAMES + 1);
  localparam int CHW = 3 * COLOR_W;
  localparam int FW  = 6 * COLOR_W + CODE_W;

  localparam logic [CCW-1:0]    L_COLS  = CCW'(COLS);
  localparam logic [RCW-1:0]    L_ROWS  = RCW'(ROWS);
  localparam logic [GW-1:0]     L_GMAX  = GW'(GLYPH_H - 1);
  localparam logic [GW-1:0]     L_GCUR  = GW'(GLYPH_H - 2);
  localparam logic [ADDR_W-1:0] L_ACOLS = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_AEND  = ADDR_W'(COLS * ROWS);
  localparam logic [BW-1:0]     L_BMAX  = BW'(BLINK_FRAMES - 1);

  logic [2:0]        r_px;
  logic [CCW-1:0]    r_col;
  logic [GW-1:0]     r_gy;
  logic [RCW-1:0]    r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr_hold;
  logic              r_frame_valid;
  logic              r_de_prev;
  logic              r_cur_en;
  logic [CCW-1:0]    r_cur_col;
  logic [RCW-1:0]    r_cur_row;
  logic [BW-1:0]     r_bcnt;
  logic              r_bphase;
  logic              r_blink;
  logic              r_v1, r_v2, r_hit1, r_hit2;
  logic [2:0]        r_px1, r_px2;
  logic [GW-1:0]     r_gy1;
  logic [CHW-1:0]    r_fg, r_bg, r_rgb;
  logic [2:0]        r_de_d, r_hs_d, r_vs_d;

  logic              w_fall;
  logic              w_in_area;
  logic              w_v0;
  logic              w_hit0;
  logic              w_on;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W-1:0] w_base_load;
  logic [ADDR_W-1:0] w_base_next;

  assign w_fall      = r_de_prev & ~bus.display_on;
  assign w_in_area   = r_frame_valid & (r_col < L_COLS) & (r_row < L_ROWS);
  assign w_cur_addr  = r_row_base + ADDR_W'(r_col);
  assign w_base_load = (RCW'(bus.scroll_row) < L_ROWS) ? ADDR_W'(bus.scroll_row) * L_ACOLS : '0;
  assign w_base_next = r_row_base + L_ACOLS;
  assign w_v0        = bus.display_on & w_in_area;
  assign w_hit0      = r_cur_en & r_blink & (r_col == r_cur_col) & (r_row == r_cur_row)
                       & (r_gy >= L_GCUR);
  assign w_on        = bus.rom_data[r_px2] | r_hit2;

  assign bus.fb_addr   = w_in_area ? w_cur_addr : r_addr_hold;
  assign bus.rom_code  = bus.fb_rdata[CODE_W-1:0];
  assign bus.rom_row   = r_gy1;
  assign bus.vga_red   = r_rgb[CHW-1 -: COLOR_W];
  assign bus.vga_green = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.vga_blue  = r_rgb[COLOR_W-1:0];
  assign bus.de_out    = r_de_d[2];
  assign bus.vga_hsync = (SYNC_ACTIVE_LOW != 0) ? ~r_hs_d[2] : r_hs_d[2];
  assign bus.vga_vsync = (SYNC_ACTIVE_LOW != 0) ? ~r_vs_d[2] : r_vs_d[2];

  // Screen position counters; frame_start overrides line-end and pixel advance
  always_ff @(posedge pixclk) begin
    if (!reset_pix_n) begin
      r_px          <= '0;
      r_col         <= '0;
      r_gy          <= '0;
      r_row         <= '0;
      r_row_base    <= '0;
      r_frame_valid <= 1'b0;
      r_de_prev     <= 1'b0;
    end else begin
      r_de_prev <= bus.display_on;
      if (bus.frame_start) begin
        r_px          <= '0;
        r_col         <= '0;
        r_gy          <= '0;
        r_row         <= '0;
        r_row_base    <= w_base_load;
        r_frame_valid <= 1'b1;
      end else if (w_fall) begin
        r_px  <= '0;
        r_col <= '0;
        if (r_gy == L_GMAX) begin
          r_gy       <= '0;
          r_row_base <= (w_base_next == L_AEND) ? '0 : w_base_next;
          if (r_row != L_ROWS) r_row <= r_row + 1'b1;
        end else begin
          r_gy <= r_gy + 1'b1;
        end
      end else if (bus.display_on) begin
        r_px <= r_px + 1'b1;
        if (r_px == 3'd7 && r_col != L_COLS) r_col <= r_col + 1'b1;
      end
    end
  end

  // Cursor config capture and blink phase, both advanced once per frame
  always_ff @(posedge pixclk) begin
    if (!reset_pix_n) begin
      r_cur_en  <= 1'b0;
      r_cur_col <= '0;
      r_cur_row <= '0;
      r_bcnt    <= '0;
      r_bphase  <= 1'b0;
      r_blink   <= 1'b0;
    end else if (bus.frame_start) begin
      r_cur_en  <= bus.cursor_en & (CCW'(bus.cursor_col) < L_COLS)
                   & (RCW'(bus.cursor_row) < L_ROWS);
      r_cur_col <= CCW'(bus.cursor_col);
      r_cur_row <= RCW'(bus.cursor_row);
      r_blink   <= r_bphase;
      if (r_bcnt == L_BMAX) begin
        r_bcnt   <= '0;
        r_bphase <= ~r_bphase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Last in-area address, presented while outside the text area
  always_ff @(posedge pixclk) begin
    if (!reset_pix_n) r_addr_hold <= '0;
    else if (w_in_area) r_addr_hold <= w_cur_addr;
  end

  // T1/T2/T3 pixel pipeline plus matching sync/de delay lines
  always_ff @(posedge pixclk) begin
    if (!reset_pix_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_hit1 <= 1'b0;
      r_hit2 <= 1'b0;
      r_px1  <= '0;
      r_px2  <= '0;
      r_gy1  <= '0;
      r_fg   <= '0;
      r_bg   <= '0;
      r_rgb  <= '0;
      r_de_d <= '0;
      r_hs_d <= '0;
      r_vs_d <= '0;
    end else begin
      r_v1   <= w_v0;
      r_hit1 <= w_hit0;
      r_px1  <= r_px;
      r_gy1  <= r_gy;
      r_v2   <= r_v1;
      r_hit2 <= r_hit1;
      r_px2  <= r_px1;
      r_fg   <= bus.fb_rdata[FW-1 -: CHW];
      r_bg   <= bus.fb_rdata[CODE_W +: CHW];
      r_rgb  <= r_v2 ? (w_on ? r_fg : r_bg) : '0;
      r_de_d <= {r_de_d[1:0], bus.display_on};
      r_hs_d <= {r_hs_d[1:0], bus.h_sync_in};
      r_vs_d <= {r_vs_d[1:0], bus.v_sync_in};
    end
  end
endmodule
